// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multicycle MIPS datapath
//
// Sequences FETCH/DECODE/execute/writeback states for R-type, jr, j, jal,
// addi, slti, andi, ori, xori, lui, lw, sw, beq and bne, driving the
// datapath's write strobes and mux selects from the current state.
//
// Optional feature macro: MEM_WAIT_EN (memory handshake on mem_ready with
// an 8-bit wait counter and MEM_TIMEOUT abort).
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   opcode, funct         IR[31:26] and IR[5:0]
//   zero                  ALU zero flag (BRANCH)
//   mem_ready             memory done (MEM_WAIT_EN only)
//   PCWrite IorD IRWrite MemRead MemWrite MemtoReg RegWrite isJAL
//   RegDst[1:0] ALUSrcA ALUSrcB[1:0] ALUOp[2:0] PCSource[1:0]
//   state[3:0]            current state (debug)
//   instr_done            final cycle of each instruction
//   illegal               unsupported opcode seen in DECODE
//   mem_err               memory wait timeout
module multicycle_control #(
  parameter logic [5:0]  JR_FUNCT    = 6'b001000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       isJAL,
  output logic [1:0] RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_REXEC    = 4'd6,
    S_RWB      = 4'd7,
    S_IEXEC    = 4'd8,
    S_IWB      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e state_q, state_d;

`ifdef MEM_WAIT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_state;
  logic       timeout;

  // Counter holds the number of cycles already spent waiting in this state.
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);
  assign timeout   = mem_state && !mem_ready && (wait_cnt_q == TIMEOUT_LAST);

  always_comb begin
    wait_cnt_d = '0;
    if (mem_state && !mem_ready && !timeout) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end
`else
  logic unused_mem_wait;
  assign unused_mem_wait = mem_ready ^ (^8'(MEM_TIMEOUT));
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
`ifdef MEM_WAIT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_WAIT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    isJAL      = 1'b0;
    RegDst     = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 3'b000;
    PCSource   = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
`ifdef MEM_WAIT_EN
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          mem_err    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
`else
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        state_d = S_DECODE;
`endif
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADDR;
          OP_RTYPE:       state_d = (funct == JR_FUNCT) ? S_JR : S_REXEC;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                          state_d = S_IEXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
`ifdef MEM_WAIT_EN
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          mem_err    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
`else
        state_d = S_MEMWB;
`endif
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
`ifdef MEM_WAIT_EN
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (timeout) begin
          mem_err    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
`else
        instr_done = 1'b1;
        state_d    = S_FETCH;
`endif
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (opcode)
          OP_SLTI: ALUOp = 3'b011;
          OP_ANDI: ALUOp = 3'b100;
          OP_ORI:  ALUOp = 3'b101;
          OP_XORI: ALUOp = 3'b110;
          OP_LUI:  ALUOp = 3'b111;
          default: ALUOp = 3'b000;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 3'b001;
        PCSource   = 2'b01;
        PCWrite    = (opcode == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC still holds PC+4 this cycle, so it is the link value.
        PCSource   = 2'b10;
        PCWrite    = 1'b1;
        RegWrite   = 1'b1;
        RegDst     = 2'b10;
        isJAL      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        PCSource   = 2'b11;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // An instruction interrupted by reset must not write anything.
    if (reset) begin
      {PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, isJAL} = '0;
      {RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource} = '0;
      {instr_done, illegal, mem_err} = '0;
    end
  end

endmodule
